// File: rtl/construtor_caminho_pkg.sv
// Shared state encoding and sizing defaults for the path builder.
// MAX_PASSOS defaults to one visit per addressable node.
package construtor_caminho_pkg;

  localparam int ADDR_WIDTH_PADRAO = 6;
  localparam int CONT_WIDTH_PADRAO = 7;

  function automatic int max_passos_de(input int addr_width);
    return 2 ** addr_width;
  endfunction

  localparam int MAX_PASSOS_PADRAO = max_passos_de(ADDR_WIDTH_PADRAO);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    EMITIR  = 3'd1,
    LER     = 3'd2,
    CAPTURA = 3'd3,
    FIM     = 3'd4,
    ERRO    = 3'd5
  } estado_t;

endpackage

// File: rtl/construtor_caminho.sv
// Walks the predecessor memory from destino back to fonte, emitting one node per hop
// over a valid/lido handshake; 3 cycles from lido to the next valid, unlimited backpressure.
module construtor_caminho
  import construtor_caminho_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_PADRAO,
  parameter int MAX_PASSOS = max_passos_de(ADDR_WIDTH),
  parameter int CONT_WIDTH = CONT_WIDTH_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  ant_rd_en_out,
  output logic [ADDR_WIDTH-1:0] ant_rd_addr_out,
  input  logic [ADDR_WIDTH-1:0] ant_rd_data_in,
  output logic                  caminho_valid_out,
  output logic [ADDR_WIDTH-1:0] caminho_addr_out,
  input  logic                  lido_in,
  output logic                  caminho_pronto_out,
  output logic                  erro_out,
  output logic                  ocupado_out,
  output logic [CONT_WIDTH-1:0] comprimento_out
);

  localparam logic [CONT_WIDTH-1:0] LIMITE = CONT_WIDTH'(MAX_PASSOS);

  estado_t               estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0] atual_q, atual_d;
  logic [CONT_WIDTH-1:0] comp_q, comp_d;
  logic [CONT_WIDTH-1:0] comp_inc;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  pronto_q, pronto_d;
  logic                  erro_q, erro_d;
  logic                  ocupado_q, ocupado_d;

  assign comp_inc = comp_q + 1'b1;

  always_comb begin
    estado_d  = estado_q;
    fonte_d   = fonte_q;
    atual_d   = atual_q;
    comp_d    = comp_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    pronto_d  = 1'b0;
    erro_d    = erro_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar_in) begin
          fonte_d  = fonte_in;
          atual_d  = destino_in;
          comp_d   = '0;
          erro_d   = 1'b0;
          valid_d  = 1'b1;
          addr_d   = destino_in;
          estado_d = EMITIR;
        end
      end
      EMITIR: begin
        if (lido_in && valid_q) begin
          comp_d  = comp_inc;
          valid_d = 1'b0;
          if (atual_q == fonte_q) begin
            pronto_d = 1'b1;
            estado_d = FIM;
          end else if (comp_inc == LIMITE) begin
            // Path never reached fonte: predecessor chain loops or is corrupt.
            erro_d   = 1'b1;
            estado_d = ERRO;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = atual_q;
            estado_d  = LER;
          end
        end
      end
      LER:     estado_d = CAPTURA;
      CAPTURA: begin
        atual_d  = ant_rd_data_in;
        valid_d  = 1'b1;
        addr_d   = ant_rd_data_in;
        estado_d = EMITIR;
      end
      FIM:     estado_d = OCIOSO;
      ERRO:    estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      fonte_q   <= '0;
      atual_q   <= '0;
      comp_q    <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      fonte_q   <= fonte_d;
      atual_q   <= atual_d;
      comp_q    <= comp_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ant_rd_en_out      = rd_en_q;
  assign ant_rd_addr_out    = rd_addr_q;
  assign caminho_valid_out  = valid_q;
  assign caminho_addr_out   = addr_q;
  assign caminho_pronto_out = pronto_q;
  assign erro_out           = erro_q;
  assign ocupado_out        = ocupado_q;
  assign comprimento_out    = comp_q;

endmodule

// File: tb/tb_construtor_caminho.sv
// Directed bench for construtor_caminho: predecessor memory model plus a per-cycle driver
// that records accepted nodes, memory reads, pronto pulses and hop latency.
module tb_construtor_caminho;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar_in = 1'b0;
  logic [5:0] fonte_in = '0;
  logic [5:0] destino_in = '0;
  logic       ant_rd_en_out;
  logic [5:0] ant_rd_addr_out;
  logic [5:0] ant_rd_data_in = '0;
  logic       caminho_valid_out;
  logic [5:0] caminho_addr_out;
  logic       lido_in = 1'b0;
  logic       caminho_pronto_out;
  logic       erro_out;
  logic       ocupado_out;
  logic [6:0] comprimento_out;

  construtor_caminho dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .iniciar_in         (iniciar_in),
    .fonte_in           (fonte_in),
    .destino_in         (destino_in),
    .ant_rd_en_out      (ant_rd_en_out),
    .ant_rd_addr_out    (ant_rd_addr_out),
    .ant_rd_data_in     (ant_rd_data_in),
    .caminho_valid_out  (caminho_valid_out),
    .caminho_addr_out   (caminho_addr_out),
    .lido_in            (lido_in),
    .caminho_pronto_out (caminho_pronto_out),
    .erro_out           (erro_out),
    .ocupado_out        (ocupado_out),
    .comprimento_out    (comprimento_out)
  );

  always #5 clk = ~clk;

  logic [5:0] ant [64];
  always @(posedge clk) if (ant_rd_en_out) ant_rd_data_in <= ant[ant_rd_addr_out];

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] acc_q[$];
  logic [5:0] rd_q[$];
  int   pronto_cnt, hop_bad, stall_bad, stall_rest, first_valid_cyc;
  logic timed_out, first_erro;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input logic [5:0] f, input logic [5:0] d);
    @(negedge clk);
    fonte_in   = f;
    destino_in = d;
    iniciar_in = 1'b1;
  endtask

  task automatic run_walk(input int stall_node, input int stall_len, input int inject_cyc, input int budget);
    int   cyc = 0;
    int   last_acc = -1;
    logic prev_valid = 1'b0;
    logic stalling = 1'b0;
    logic done = 1'b0;
    acc_q.delete();
    rd_q.delete();
    pronto_cnt = 0; hop_bad = 0; stall_bad = 0; first_valid_cyc = -1;
    stall_rest = stall_len;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        iniciar_in = 1'b0;
        first_erro = erro_out;
      end
      if (cyc == inject_cyc) begin
        iniciar_in = 1'b1; fonte_in = 6'd20; destino_in = 6'd20;
      end else if (cyc == inject_cyc + 1) begin
        iniciar_in = 1'b0;
      end
      if (ant_rd_en_out) rd_q.push_back(ant_rd_addr_out);
      if (caminho_pronto_out) pronto_cnt++;
      if (caminho_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (caminho_valid_out && !prev_valid && last_acc >= 0 && cyc - last_acc != 3) hop_bad++;
      lido_in = 1'b1;
      if (stall_rest > 0 && (stalling || (caminho_valid_out && caminho_addr_out == 6'(stall_node)))) begin
        stalling = 1'b1;
        if (!(caminho_valid_out && caminho_addr_out == 6'(stall_node))) stall_bad++;
        lido_in = 1'b0;
        stall_rest--;
      end
      if (caminho_valid_out && lido_in) begin
        acc_q.push_back(caminho_addr_out);
        last_acc = cyc;
      end
      prev_valid = caminho_valid_out;
      if (!ocupado_out) done = 1'b1;
    end
    lido_in   = 1'b0;
    timed_out = !done;
  endtask

  task automatic verify_basic(input string tag);
    logic [5:0] exp_n[3];
    exp_n[0] = 6'd12; exp_n[1] = 6'd5; exp_n[2] = 6'd3;
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_nodes"}, acc_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_node%0d", tag, i), (acc_q.size() > i) ? acc_q[i] : 6'h3f, exp_n[i]);
    check({tag, "_reads"}, rd_q.size(), 2);
    check({tag, "_rd0"}, (rd_q.size() > 0) ? rd_q[0] : 6'h3f, 12);
    check({tag, "_rd1"}, (rd_q.size() > 1) ? rd_q[1] : 6'h3f, 5);
    check({tag, "_pronto"}, pronto_cnt, 1);
    check({tag, "_comp"}, comprimento_out, 3);
    check({tag, "_erro"}, erro_out, 0);
    check({tag, "_hop_lat"}, hop_bad, 0);
    check({tag, "_first_lat"}, first_valid_cyc, 1);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 64; i++) ant[i] = 6'h3f;
    ant[12] = 6'd5; ant[5] = 6'd3;
    ant[10] = 6'd11; ant[11] = 6'd10;

    #12;
    check("reset_outputs", {ant_rd_en_out, ant_rd_addr_out, caminho_valid_out, caminho_addr_out,
                            caminho_pronto_out, erro_out, ocupado_out, comprimento_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic walk, lido held high
    start(6'd3, 6'd12);
    run_walk(-1, 0, -1, 100);
    verify_basic("basic");

    // Backpressure on node 5
    start(6'd3, 6'd12);
    run_walk(5, 4, -1, 100);
    verify_basic("stall");
    check("stall_stable", stall_bad, 0);
    check("stall_done", stall_rest, 0);

    // Trivial path
    start(6'd7, 6'd7);
    run_walk(-1, 0, -1, 100);
    check("triv_timeout", timed_out, 0);
    check("triv_nodes", acc_q.size(), 1);
    check("triv_node0", (acc_q.size() > 0) ? acc_q[0] : 6'h3f, 7);
    check("triv_reads", rd_q.size(), 0);
    check("triv_pronto", pronto_cnt, 1);
    check("triv_comp", comprimento_out, 1);

    // Predecessor loop never reaches fonte
    start(6'd0, 6'd10);
    run_walk(-1, 0, -1, 1000);
    check("loop_timeout", timed_out, 0);
    check("loop_nodes", acc_q.size(), 64);
    bad = 0;
    foreach (acc_q[i]) if (acc_q[i] != ((i % 2) ? 6'd11 : 6'd10)) bad++;
    check("loop_alternate", bad, 0);
    check("loop_reads", rd_q.size(), 63);
    check("loop_erro", erro_out, 1);
    check("loop_pronto", pronto_cnt, 0);
    check("loop_comp", comprimento_out, 64);

    // Busy start ignored; this accepted start must also clear the sticky error
    start(6'd3, 6'd12);
    run_walk(-1, 0, 2, 100);
    check("clear_erro", first_erro, 0);
    verify_basic("busy");

    // Reset while reading the predecessor memory
    start(6'd3, 6'd12);
    bad = 1;
    for (int c = 0; c < 20 && bad; c++) begin
      @(negedge clk);
      iniciar_in = 1'b0;
      lido_in = 1'b1;
      if (ant_rd_en_out) bad = 0;
    end
    check("rst_reached_ler", bad, 0);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {ant_rd_en_out, ant_rd_addr_out, caminho_valid_out, caminho_addr_out,
                          caminho_pronto_out, erro_out, ocupado_out, comprimento_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (caminho_valid_out || ocupado_out || ant_rd_en_out) bad++;
    end
    lido_in = 1'b0;
    check("rst_quiet", bad, 0);
    start(6'd3, 6'd12);
    run_walk(-1, 0, -1, 100);
    verify_basic("rst_fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
